// File: rtl/conv_bridge_pkg.sv
// rtl/conv_bridge_pkg.sv - shared widths, shape codes and FSM encoding for the convolver stream bridge
package conv_bridge_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int ADDR_W_DEF   = 5;
    localparam int Z_DATA_W_DEF = 16;
    localparam int Z_ADDR_W_DEF = 6;

    localparam logic SHAPE_FULL = 1'b1;
    localparam logic SHAPE_SAME = 1'b0;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD_X  = 4'd1,
        ST_LOAD_Y  = 4'd2,
        ST_START   = 4'd3,
        ST_WAIT    = 4'd4,
        ST_RD_ADDR = 4'd5,
        ST_RD_DATA = 4'd6,
        ST_OUT     = 4'd7,
        ST_DONE    = 4'd8
    } state_e;

endpackage

// File: rtl/conv_bridge_out_reg.sv
// rtl/conv_bridge_out_reg.sv - output hold register: load strobe captures a word, held until ready
module conv_bridge_out_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         last_i,
    input  logic         m_ready_i,
    output logic [W-1:0] m_data_o,
    output logic         m_valid_o,
    output logic         m_last_o,
    output logic         fire_o
);

    logic [W-1:0] data_q;
    logic         valid_q;
    logic         last_q;

    assign fire_o    = valid_q & m_ready_i;
    assign m_data_o  = data_q;
    assign m_valid_o = valid_q;
    assign m_last_o  = last_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
            last_q  <= last_i;
        end else if (fire_o) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

endmodule

// File: rtl/conv_stream_bridge.sv
// rtl/conv_stream_bridge.sv - loads X/Y memories from a stream, runs the convolver, streams Z results out
module conv_stream_bridge
    import conv_bridge_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int Z_DATA_W = Z_DATA_W_DEF,
    parameter int Z_ADDR_W = Z_ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cmd_start_i,
    input  logic [ADDR_W:0]     cfg_size_x_i,
    input  logic [ADDR_W:0]     cfg_size_y_i,
    input  logic                cfg_shape_i,
    input  logic [DATA_W-1:0]   s_data_i,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    output logic                x_we_o,
    output logic                y_we_o,
    output logic [ADDR_W-1:0]   mem_waddr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic                conv_start_o,
    output logic                conv_shape_o,
    input  logic                conv_done_i,
    output logic [Z_ADDR_W-1:0] z_raddr_o,
    input  logic [Z_DATA_W-1:0] z_rdata_i,
    output logic [Z_DATA_W-1:0] m_data_o,
    output logic                m_valid_o,
    output logic                m_last_o,
    input  logic                m_ready_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    localparam logic [ADDR_W:0]     MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [Z_ADDR_W-1:0] Z_ONE   = {{(Z_ADDR_W-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [Z_ADDR_W-1:0] cnt_q, cnt_d, nz_q, nz_d, cnt_inc;
    logic [ADDR_W:0]     size_x_q, size_x_d, size_y_q, size_y_d;
    logic                shape_q, shape_d;
    logic                err_q, err_d;
    logic                x_we_q, y_we_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                s_fire, cfg_bad, out_load, out_last, m_fire;

    assign cnt_inc  = cnt_q + Z_ONE;
    assign s_fire   = s_valid_i & s_ready_o;
    assign out_last = (cnt_q == nz_q - Z_ONE);
    assign cfg_bad  = (cfg_size_x_i == '0) || (cfg_size_y_i == '0) ||
                      (cfg_size_x_i > MAX_LEN) || (cfg_size_y_i > MAX_LEN);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        nz_d     = nz_q;
        size_x_d = size_x_q;
        size_y_d = size_y_q;
        shape_d  = shape_q;
        err_d    = 1'b0;
        out_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_start_i) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        size_x_d = cfg_size_x_i;
                        size_y_d = cfg_size_y_i;
                        shape_d  = cfg_shape_i;
                        nz_d     = (cfg_shape_i == SHAPE_FULL)
                                 ? Z_ADDR_W'(cfg_size_x_i) + Z_ADDR_W'(cfg_size_y_i) - Z_ONE
                                 : Z_ADDR_W'(cfg_size_x_i);
                        cnt_d    = '0;
                        state_d  = ST_LOAD_X;
                    end
                end
            end
            ST_LOAD_X: begin
                if (s_fire) begin
                    if (cnt_inc == Z_ADDR_W'(size_x_q)) begin
                        cnt_d   = '0;
                        state_d = ST_LOAD_Y;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_LOAD_Y: begin
                if (s_fire) begin
                    if (cnt_inc == Z_ADDR_W'(size_y_q)) begin
                        cnt_d   = '0;
                        state_d = ST_START;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (conv_done_i) begin
                    cnt_d   = '0;
                    state_d = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: state_d = ST_RD_DATA;
            ST_RD_DATA: begin
                out_load = 1'b1;
                state_d  = ST_OUT;
            end
            ST_OUT: begin
                if (m_fire) begin
                    if (m_last_o) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_inc;
                        state_d = ST_RD_ADDR;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            nz_q     <= '0;
            size_x_q <= '0;
            size_y_q <= '0;
            shape_q  <= 1'b0;
            err_q    <= 1'b0;
            x_we_q   <= 1'b0;
            y_we_q   <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            nz_q     <= nz_d;
            size_x_q <= size_x_d;
            size_y_q <= size_y_d;
            shape_q  <= shape_d;
            err_q    <= err_d;
            x_we_q   <= s_fire && (state_q == ST_LOAD_X);
            y_we_q   <= s_fire && (state_q == ST_LOAD_Y);
            if (s_fire) begin
                waddr_q <= cnt_q[ADDR_W-1:0];
                wdata_q <= s_data_i;
            end
        end
    end

    // Address is held through RD_DATA so either a registered or a flow-through Z memory works.
    assign z_raddr_o    = (state_q == ST_RD_ADDR || state_q == ST_RD_DATA) ? cnt_q : '0;
    assign s_ready_o    = (state_q == ST_LOAD_X) || (state_q == ST_LOAD_Y);
    assign x_we_o       = x_we_q;
    assign y_we_o       = y_we_q;
    assign mem_waddr_o  = waddr_q;
    assign mem_wdata_o  = wdata_q;
    assign conv_start_o = (state_q == ST_START);
    assign conv_shape_o = shape_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);
    assign err_o        = err_q;

    conv_bridge_out_reg #(.W(Z_DATA_W)) u_out_reg (
        .clk      (clk),
        .rstn     (rstn),
        .load_i   (out_load),
        .data_i   (z_rdata_i),
        .last_i   (out_last),
        .m_ready_i(m_ready_i),
        .m_data_o (m_data_o),
        .m_valid_o(m_valid_o),
        .m_last_o (m_last_o),
        .fire_o   (m_fire)
    );

endmodule
